uart_num_parser: RTL and testbench

//   Receive-side counterpart of matrix_uart_sender. Turns the raw ASCII byte stream from

---
 rtl/uart_num_parser.sv | 165 ++++++++++++++++
 tb/tb_uart_num_parser.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_num_parser.sv
// uart_num_parser: turns a received ASCII byte stream into signed integer
// tokens and line-end events. Every byte delivered with rx_done produces its
// pulses (num_valid / line_end / err_char / err_ovf) exactly one cycle later.
module uart_num_parser #(
  parameter int ELEM_W     = 8,
  parameter int MAX_DIGITS = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic              num_valid,
  output logic [ELEM_W-1:0] num_data,
  output logic              line_end,
  output logic              err_char,
  output logic              err_ovf
);

  // Four extra bits so acc*10+9 cannot wrap before the range check.
  localparam int ACC_W = ELEM_W + 4;
  localparam int CNT_W = $clog2(MAX_DIGITS + 2);

  localparam logic [ACC_W-1:0] LIM_POS = ACC_W'((64'd1 << (ELEM_W - 1)) - 64'd1);
  localparam logic [ACC_W-1:0] LIM_NEG = ACC_W'(64'd1 << (ELEM_W - 1));
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SIGN,
    S_DIGITS,
    S_DROP
  } state_t;

  state_t            r_state;
  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_neg;
  logic              r_cr_seen;

  logic              w_is_dig;
  logic              w_is_min;
  logic              w_is_sep;
  logic              w_is_cr;
  logic              w_is_lf;
  logic              w_is_nl;
  logic              w_skip_lf;
  logic              w_ovf;
  logic [ACC_W-1:0]  w_digit;
  logic [ACC_W-1:0]  w_acc_next;
  logic [ACC_W-1:0]  w_limit;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [ELEM_W-1:0] w_mag;
  logic [ELEM_W-1:0] w_tok;

  // Classify the incoming byte and precompute the next accumulator value.
  always_comb begin
    w_is_dig   = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    w_is_min   = (rx_data == 8'h2D);
    w_is_sep   = (rx_data == 8'h20) || (rx_data == 8'h09) || (rx_data == 8'h2C);
    w_is_cr    = (rx_data == 8'h0D);
    w_is_lf    = (rx_data == 8'h0A);
    w_is_nl    = w_is_cr || w_is_lf;
    // LF completing a CRLF pair is swallowed without any effect.
    w_skip_lf  = w_is_lf && r_cr_seen;
    w_digit    = {{(ACC_W - 4){1'b0}}, rx_data[3:0]};
    w_acc_next = (r_acc << 3) + (r_acc << 1) + w_digit;
    w_cnt_next = r_cnt + CNT_W'(1);
    w_limit    = r_neg ? LIM_NEG : LIM_POS;
    w_ovf      = (w_cnt_next > CNT_MAX) || (w_acc_next > w_limit);
    w_mag      = r_acc[ELEM_W-1:0];
    w_tok      = r_neg ? -w_mag : w_mag;
  end

  // Parser FSM with registered single-cycle pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_cr_seen <= 1'b0;
      num_valid <= 1'b0;
      num_data  <= '0;
      line_end  <= 1'b0;
      err_char  <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      num_valid <= 1'b0;
      line_end  <= 1'b0;
      err_char  <= 1'b0;
      err_ovf   <= 1'b0;
      if (clr) begin
        r_state   <= S_IDLE;
        r_acc     <= '0;
        r_cnt     <= '0;
        r_neg     <= 1'b0;
        r_cr_seen <= 1'b0;
      end else if (rx_done) begin
        r_cr_seen <= w_is_cr;
        if (!w_skip_lf) begin
          case (r_state)
            S_IDLE: begin
              if (w_is_dig) begin
                r_acc   <= w_digit;
                r_cnt   <= CNT_W'(1);
                r_neg   <= 1'b0;
                r_state <= S_DIGITS;
              end else if (w_is_min) begin
                r_neg   <= 1'b1;
                r_state <= S_SIGN;
              end else if (w_is_nl) begin
                line_end <= 1'b1;
              end else if (!w_is_sep) begin
                err_char <= 1'b1;
                r_state  <= S_DROP;
              end
            end
            S_SIGN: begin
              if (w_is_dig) begin
                r_acc   <= w_digit;
                r_cnt   <= CNT_W'(1);
                r_state <= S_DIGITS;
              end else if (w_is_sep || w_is_nl) begin
                err_char <= 1'b1;
                line_end <= w_is_nl;
                r_state  <= S_IDLE;
              end else begin
                err_char <= 1'b1;
                r_state  <= S_DROP;
              end
            end
            S_DIGITS: begin
              if (w_is_dig) begin
                if (w_ovf) begin
                  err_ovf <= 1'b1;
                  r_state <= S_DROP;
                end else begin
                  r_acc <= w_acc_next;
                  r_cnt <= w_cnt_next;
                end
              end else if (w_is_sep || w_is_nl) begin
                num_valid <= 1'b1;
                num_data  <= w_tok;
                line_end  <= w_is_nl;
                r_state   <= S_IDLE;
              end else begin
                err_char <= 1'b1;
                r_state  <= S_DROP;
              end
            end
            S_DROP: begin
              if (w_is_sep || w_is_nl) begin
                line_end <= w_is_nl;
                r_state  <= S_IDLE;
              end
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_num_parser.sv
// Randomised scoreboard bench for uart_num_parser: a token-level reference
// model predicts the pulse set one cycle after each byte; a monitor compares.
module tb_uart_num_parser;

  localparam int ELEM_W     = 8;
  localparam int MAX_DIGITS = 3;
  localparam int VMAX       = (1 << (ELEM_W - 1)) - 1;
  localparam int VMIN       = -(1 << (ELEM_W - 1));

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clr;
  logic [7:0]        rx_data;
  logic              rx_done;
  logic              num_valid;
  logic [ELEM_W-1:0] num_data;
  logic              line_end;
  logic              err_char;
  logic              err_ovf;

  uart_num_parser #(.ELEM_W(ELEM_W), .MAX_DIGITS(MAX_DIGITS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .num_valid(num_valid),
    .num_data (num_data),
    .line_end (line_end),
    .err_char (err_char),
    .err_ovf  (err_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // {num_valid, num_data, line_end, err_char, err_ovf}
  typedef struct {
    int          cyc;
    logic [11:0] v;
  } ev_t;
  ev_t q[$];

  // Reference model: the pending token is "optional minus + digits so far".
  bit          m_minus;
  bit          m_drop;
  bit          m_cr;
  int          m_ndig;
  int          m_mag;
  logic [7:0]  m_last;

  task automatic m_clear_tok();
    m_minus = 0;
    m_ndig  = 0;
    m_mag   = 0;
  endtask

  task automatic m_clr();
    m_clear_tok();
    m_drop = 0;
    m_cr   = 0;
  endtask

  task automatic m_reset();
    m_clr();
    m_last = '0;
  endtask

  task automatic model_byte(input logic [7:0] c);
    bit   dig, sep, nl, nv, le, ec, eo;
    int   val;
    ev_t  e;
    dig = (c >= 8'h30) && (c <= 8'h39);
    sep = (c == 8'h20) || (c == 8'h09) || (c == 8'h2C);
    nl  = (c == 8'h0D) || (c == 8'h0A);
    nv = 0; le = 0; ec = 0; eo = 0;
    if (c == 8'h0A && m_cr) begin
      m_cr = 0;
      return;
    end
    m_cr = (c == 8'h0D);
    if (m_drop) begin
      if (sep || nl) begin
        m_drop = 0;
        le     = nl;
        m_clear_tok();
      end
    end else if (dig) begin
      m_ndig = m_ndig + 1;
      m_mag  = m_mag * 10 + int'(c - 8'h30);
      val    = m_minus ? -m_mag : m_mag;
      if (m_ndig > MAX_DIGITS || val > VMAX || val < VMIN) begin
        eo     = 1;
        m_drop = 1;
        m_clear_tok();
      end
    end else if (c == 8'h2D) begin
      if (!m_minus && m_ndig == 0) m_minus = 1;
      else begin
        ec     = 1;
        m_drop = 1;
        m_clear_tok();
      end
    end else if (sep || nl) begin
      le = nl;
      if (m_ndig > 0) begin
        val    = m_minus ? -m_mag : m_mag;
        nv     = 1;
        m_last = val[7:0];
      end else if (m_minus) begin
        ec = 1;
      end
      m_clear_tok();
    end else begin
      ec     = 1;
      m_drop = 1;
      m_clear_tok();
    end
    if (nv || le || ec || eo) begin
      e.cyc = cyc + 1;
      e.v   = {nv, m_last, le, ec, eo};
      q.push_back(e);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  // Monitor: flags missed, unexpected and wrong pulse sets.
  always @(negedge clk) begin
    logic [11:0] got;
    ev_t         e;
    if (rst_n) begin
      got = {num_valid, num_data, line_end, err_char, err_ovf};
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL missing_event: cycle %0d got none required %h", e.cyc, e.v);
      end
      if (num_valid || line_end || err_char || err_ovf) begin
        n_cmp++;
        if (err_char && err_ovf) begin
          n_bad++;
          $display("FAIL err_exclusive: cycle %0d got both errors required at most one", cyc);
        end
        n_cmp++;
        if (q.size() == 0 || q[0].cyc != cyc) begin
          n_bad++;
          $display("FAIL unexpected_event: cycle %0d got %h required no pulses", cyc, got);
        end else begin
          e = q.pop_front();
          if (got !== e.v) begin
            n_bad++;
            $display("FAIL event: cycle %0d got %h required %h", cyc, got, e.v);
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] c);
    rx_data = c;
    rx_done = 1'b1;
    model_byte(c);
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_cycle(input bit with_byte, input logic [7:0] c);
    clr     = 1'b1;
    rx_data = c;
    rx_done = with_byte;
    m_clr();
    @(negedge clk);
    clr     = 1'b0;
    rx_done = 1'b0;
  endtask

  function automatic logic [7:0] rand_byte();
    int unsigned r;
    r = $urandom_range(0, 99);
    if (r < 50)      return 8'h30 + 8'($urandom_range(0, 9));
    else if (r < 58) return 8'h2D;
    else if (r < 70) return 8'h20;
    else if (r < 74) return 8'h09;
    else if (r < 80) return 8'h2C;
    else if (r < 86) return 8'h0D;
    else if (r < 92) return 8'h0A;
    else             return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n   = 1'b0;
    clr     = 1'b0;
    rx_done = 1'b0;
    rx_data = '0;
    m_reset();
    idle(3);
    chk("reset_outputs", 32'({num_valid, num_data, line_end, err_char, err_ovf}), 32'd0);
    rst_n = 1'b1;
    idle(1);

    send_str("12 -5\n");
    idle(2);
    send_str("127 -128 128 ");
    idle(2);
    send_str("3a4 7\r\n");
    idle(2);
    send_str("- 5,0012 ");
    idle(2);

    send_str("12");
    clr_cycle(1'b0, 8'h00);
    send_str("3 ");
    send_str("4");
    clr_cycle(1'b1, 8'h39);
    send_str(" 5 ");
    idle(2);

    // Asynchronous reset while collecting digits with bytes back to back.
    send_str("8 12");
    chk("hold_before_reset", 32'(num_data), 32'd8);
    rx_data = 8'h33;
    rx_done = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'({num_valid, num_data, line_end, err_char, err_ovf}), 32'd0);
    rx_done = 1'b0;
    m_reset();
    q.delete();
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send_str("6\n");
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2) clr_cycle(1'($urandom_range(0, 1)), rand_byte());
      else send(rand_byte());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(5);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
